// File: rtl/stepgen_q_if.sv
// Register-file side of one stepgen_q axis: rate, timing and mode controls in,
// position/count readback and step/dir pins out.
interface stepgen_q_if #(
  parameter int W  = 12,
  parameter int F  = 10,
  parameter int T  = 5,
  parameter int TB = 2,
  parameter int C  = 16
);
  logic                enable;
  logic                qmode;
  logic signed [F:0]   velocity;
  logic [TB-1:0]       tap;
  logic [T-1:0]        steplen;
  logic [T-1:0]        stepspace;
  logic [T-1:0]        dirhold;
  logic [T-1:0]        dirsetup;
  logic                clear_err;
  logic [W+F-1:0]      position;
  logic [C-1:0]        count;
  logic                step;
  logic                dir;
  logic                busy;
  logic                overrun;
  logic [2:0]          fsm_state;

  modport master (
    output enable, qmode, velocity, tap, steplen, stepspace, dirhold, dirsetup, clear_err,
    input  position, count, step, dir, busy, overrun, fsm_state
  );

  modport slave (
    input  enable, qmode, velocity, tap, steplen, stepspace, dirhold, dirsetup, clear_err,
    output position, count, step, dir, busy, overrun, fsm_state
  );
endinterface

// File: rtl/stepgen_q.sv
// Single-axis DDS step generator: accumulator bit toggles become step/dir pulses
// (or quadrature A/B) with programmable pulse, space, dir-hold and dir-setup times.
module stepgen_q #(
  parameter int W  = 12,
  parameter int F  = 10,
  parameter int T  = 5,
  parameter int TB = 2,
  parameter int C  = 16
) (
  input  logic       clk,
  input  logic       reset,
  stepgen_q_if.slave bus
);
  localparam int PW = W + F;
  localparam int IW = (PW > 1) ? $clog2(PW) : 1;

  typedef enum logic [2:0] {
    S_READY    = 3'd0,
    S_HIGH     = 3'd1,
    S_SPACE    = 3'd2,
    S_DIRHOLD  = 3'd3,
    S_DIRSETUP = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [T-1:0]   timer_q, timer_d;
  logic           ones_q, ones_d;
  logic           pbit_q, pbit_d;
  logic           ddir_q, ddir_d;
  logic [1:0]     phase_q, phase_d;
  logic           step_q, step_d;
  logic [C-1:0]   count_q, count_d;
  logic [PW-1:0]  pos_q, pos_d;
  logic           ovr_q, ovr_d;

  logic [PW-1:0]  xvel;
  logic           dbit;
  logic           dir_pending;
  logic           vel_nz;
  logic           pbit;
  logic           ovr_set;
  logic [IW-1:0]  pidx;
  logic [1:0]     qbin;
  logic [1:0]     qbin_n;

  assign xvel        = {{(W-1){bus.velocity[F]}}, bus.velocity};
  assign dbit        = bus.velocity[F];
  assign dir_pending = (ddir_q != dbit);
  assign vel_nz      = |bus.velocity;

  // Tap selects position[F+tap]; taps past the top of the accumulator use the MSB.
  always_comb begin
    int idx;
    idx = F + int'(bus.tap);
    if (idx > PW - 1) idx = PW - 1;
    pidx = IW'(idx);
    pbit = pos_q[pidx];
  end

  // Quadrature phase walks the Gray sequence 00,01,11,10 via its binary index.
  assign qbin   = {phase_q[1], phase_q[1] ^ phase_q[0]};
  assign qbin_n = ddir_q ? (qbin - 2'd1) : (qbin + 2'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_READY;
      timer_q <= '0;
      ones_q  <= 1'b0;
      pbit_q  <= 1'b0;
      ddir_q  <= 1'b0;
      phase_q <= 2'b00;
      step_q  <= 1'b0;
      count_q <= '0;
      pos_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ones_q  <= ones_d;
      pbit_q  <= pbit_d;
      ddir_q  <= ddir_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      count_q <= count_d;
      pos_q   <= pos_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ones_d  = ones_q;
    pbit_d  = pbit_q;
    ddir_d  = ddir_q;
    phase_d = phase_q;
    step_d  = step_q;
    count_d = count_q;
    pos_d   = pos_q;
    ovr_set = 1'b0;

    if (bus.enable) begin
      pbit_d = pbit;
      if (!dir_pending) pos_d = pos_q + xvel;
      // A pending toggle that is overtaken by another one before service is lost,
      // including the case where it flips back just as the FSM returns to READY.
      if ((pbit != pbit_q) && (pbit_q != ones_q)) ovr_set = 1'b1;

      case (state_q)
        S_READY: begin
          if (dir_pending && vel_nz) begin
            timer_d = bus.dirhold;
            state_d = S_DIRHOLD;
          end else if (pbit != ones_q) begin
            ones_d  = pbit;
            count_d = ddir_q ? (count_q - C'(1)) : (count_q + C'(1));
            if (!bus.qmode) begin
              step_d  = 1'b1;
              timer_d = bus.steplen;
              state_d = S_HIGH;
            end else begin
              phase_d = {qbin_n[1], qbin_n[1] ^ qbin_n[0]};
              timer_d = bus.stepspace;
              state_d = S_SPACE;
            end
          end
        end
        S_HIGH: begin
          if (timer_q == '0) begin
            step_d  = 1'b0;
            timer_d = bus.stepspace;
            state_d = S_SPACE;
          end else begin
            timer_d = timer_q - T'(1);
          end
        end
        S_SPACE: begin
          if (timer_q == '0) state_d = S_READY;
          else               timer_d = timer_q - T'(1);
        end
        S_DIRHOLD: begin
          if (timer_q == '0) begin
            ddir_d  = dbit;
            timer_d = bus.dirsetup;
            state_d = S_DIRSETUP;
          end else begin
            timer_d = timer_q - T'(1);
          end
        end
        S_DIRSETUP: begin
          if (timer_q == '0) state_d = S_READY;
          else               timer_d = timer_q - T'(1);
        end
        default: begin
          state_d = S_READY;
        end
      endcase
    end

    // Setting wins over a simultaneous clear so a fresh loss is never hidden.
    if (ovr_set)            ovr_d = 1'b1;
    else if (bus.clear_err) ovr_d = 1'b0;
    else                    ovr_d = ovr_q;
  end

  assign bus.position  = pos_q;
  assign bus.count     = count_q;
  assign bus.step      = bus.qmode ? phase_q[1] : step_q;
  assign bus.dir       = bus.qmode ? phase_q[0] : ddir_q;
  assign bus.busy      = (state_q != S_READY);
  assign bus.overrun   = ovr_q;
  assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_stepgen_q.sv
// Directed bench for stepgen_q: reset, rate, overrun, direction change, pulse
// widths, quadrature and enable/async-reset behaviour with hand-computed values.
module tb_stepgen_q;
  localparam int W  = 12;
  localparam int F  = 10;
  localparam int T  = 5;
  localparam int TB = 2;
  localparam int C  = 16;
  localparam int PW = W + F;

  logic clk = 1'b0;
  logic reset;

  stepgen_q_if #(.W(W), .F(F), .T(T), .TB(TB), .C(C)) bus ();

  stepgen_q #(.W(W), .F(F), .T(T), .TB(TB), .C(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [PW-1:0] pos_s   [0:40];
  logic [C-1:0]  count_s [0:40];
  logic          step_s  [0:40];
  logic          dir_s   [0:40];
  logic          busy_s  [0:40];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic record(input int k);
    pos_s[k]   = bus.position;
    count_s[k] = bus.count;
    step_s[k]  = bus.step;
    dir_s[k]   = bus.dir;
    busy_s[k]  = bus.busy;
  endtask

  task automatic set_defaults();
    bus.enable    = 1'b0;
    bus.qmode     = 1'b0;
    bus.velocity  = '0;
    bus.tap       = '0;
    bus.steplen   = '0;
    bus.stepspace = '0;
    bus.dirhold   = '0;
    bus.dirsetup  = '0;
    bus.clear_err = 1'b0;
  endtask

  task automatic do_reset();
    set_defaults();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    set_defaults();
    reset = 1'b1;
    #1;
    total++; if (bus.position !== 22'd0) begin bad++; $display("FAIL reset_position got=%0h want=0", bus.position); end
    total++; if (bus.count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0h want=0", bus.count); end
    total++; if (bus.step !== 1'b0) begin bad++; $display("FAIL reset_step got=%b want=0", bus.step); end
    total++; if (bus.dir !== 1'b0) begin bad++; $display("FAIL reset_dir got=%b want=0", bus.dir); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", bus.overrun); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  // velocity 512, tap 1: bit 11 toggles every 4 cycles; 99 of the 100 toggles
  // are served within 400 enabled cycles (the last one is served on cycle 401).
  task automatic test_basic_rate();
    int rises;
    int hi_len;
    int max_hi;
    logic prev;
    do_reset();
    bus.velocity = 11'h200;
    bus.tap      = 2'd1;
    bus.enable   = 1'b1;
    rises = 0; hi_len = 0; max_hi = 0; prev = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (bus.step && !prev) rises++;
      hi_len = bus.step ? hi_len + 1 : 0;
      if (hi_len > max_hi) max_hi = hi_len;
      prev = bus.step;
    end
    total++; if (rises != 99) begin bad++; $display("FAIL basic_rises got=%0d want=99", rises); end
    total++; if (max_hi != 1) begin bad++; $display("FAIL basic_high_len got=%0d want=1", max_hi); end
    total++; if (bus.count !== 16'd99) begin bad++; $display("FAIL basic_count got=%0d want=99", bus.count); end
    total++; if (bus.position !== 22'd204800) begin bad++; $display("FAIL basic_position got=%0d want=204800", bus.position); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL basic_overrun got=%b want=0", bus.overrun); end
    total++; if (bus.dir !== 1'b0) begin bad++; $display("FAIL basic_dir got=%b want=0", bus.dir); end
  endtask

  // tap 0: bit 10 toggles every 2 cycles, faster than the 3-cycle service period.
  task automatic test_overrun();
    do_reset();
    bus.velocity = 11'h200;
    bus.tap      = 2'd0;
    bus.enable   = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      record(k);
    end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ovr_not_yet got=%b want=0", bus.overrun); end
    repeat (2) tick();
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", bus.overrun); end
    total++; if (bus.count !== 16'd2) begin bad++; $display("FAIL ovr_count got=%0d want=2", bus.count); end
    bus.velocity  = '0;
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", bus.overrun); end
    repeat (3) tick();
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ovr_stays_clear got=%b want=0", bus.overrun); end
  endtask

  task automatic test_dir_change();
    logic any_step;
    do_reset();
    bus.velocity = 11'h200;
    bus.tap      = 2'd1;
    bus.dirhold  = 5'd3;
    bus.dirsetup = 5'd2;
    bus.enable   = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      if (k == 11) bus.velocity = 11'h600;
      tick();
      record(k);
    end
    any_step = 1'b0;
    for (int k = 11; k <= 19; k++) any_step = any_step | step_s[k];
    total++; if (pos_s[11] !== 22'd5120) begin bad++; $display("FAIL dir_freeze_start got=%0d want=5120", pos_s[11]); end
    total++; if (pos_s[15] !== 22'd5120) begin bad++; $display("FAIL dir_freeze_hold got=%0d want=5120", pos_s[15]); end
    total++; if (busy_s[13] !== 1'b1) begin bad++; $display("FAIL dir_busy got=%b want=1", busy_s[13]); end
    total++; if (dir_s[15] !== 1'b0) begin bad++; $display("FAIL dir_before_hold got=%b want=0", dir_s[15]); end
    total++; if (dir_s[16] !== 1'b1) begin bad++; $display("FAIL dir_after_hold got=%b want=1", dir_s[16]); end
    total++; if (any_step !== 1'b0) begin bad++; $display("FAIL dir_gap_step got=%b want=0", any_step); end
    total++; if (pos_s[19] !== 22'd3584) begin bad++; $display("FAIL dir_position got=%0d want=3584", pos_s[19]); end
    total++; if (count_s[19] !== 16'd2) begin bad++; $display("FAIL dir_count_before got=%0d want=2", count_s[19]); end
    total++; if (step_s[20] !== 1'b1) begin bad++; $display("FAIL dir_next_step got=%b want=1", step_s[20]); end
    total++; if (count_s[20] !== 16'd1) begin bad++; $display("FAIL dir_count_dec got=%0d want=1", count_s[20]); end
  endtask

  task automatic test_pulse_widths();
    int rises;
    int hi_len;
    int lo_len;
    logic prev;
    do_reset();
    bus.velocity  = 11'd64;
    bus.tap       = 2'd1;
    bus.steplen   = 5'd7;
    bus.stepspace = 5'd4;
    bus.enable    = 1'b1;
    rises = 0; hi_len = 0; lo_len = 0; prev = 1'b0;
    for (int k = 1; k <= 210; k++) begin
      tick();
      if (bus.step) begin
        if (!prev) begin
          rises++;
          if (rises > 1) begin
            total++; if (lo_len < 5) begin bad++; $display("FAIL pw_low got=%0d want>=5", lo_len); end
          end
        end
        hi_len++;
        lo_len = 0;
      end else begin
        if (prev) begin
          total++; if (hi_len != 8) begin bad++; $display("FAIL pw_high got=%0d want=8", hi_len); end
        end
        hi_len = 0;
        lo_len++;
      end
      prev = bus.step;
    end
    total++; if (rises != 6) begin bad++; $display("FAIL pw_rises got=%0d want=6", rises); end
  endtask

  task automatic test_quadrature();
    do_reset();
    bus.qmode    = 1'b1;
    bus.velocity = 11'd256;
    bus.tap      = 2'd1;
    bus.enable   = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      tick();
      record(k);
    end
    total++; if ({step_s[8], dir_s[8]} !== 2'b00) begin bad++; $display("FAIL quad_fwd0 got=%b want=00", {step_s[8], dir_s[8]}); end
    total++; if ({step_s[9], dir_s[9]} !== 2'b01) begin bad++; $display("FAIL quad_fwd1 got=%b want=01", {step_s[9], dir_s[9]}); end
    total++; if ({step_s[17], dir_s[17]} !== 2'b11) begin bad++; $display("FAIL quad_fwd2 got=%b want=11", {step_s[17], dir_s[17]}); end
    total++; if ({step_s[25], dir_s[25]} !== 2'b10) begin bad++; $display("FAIL quad_fwd3 got=%b want=10", {step_s[25], dir_s[25]}); end
    total++; if ({step_s[33], dir_s[33]} !== 2'b00) begin bad++; $display("FAIL quad_fwd4 got=%b want=00", {step_s[33], dir_s[33]}); end
    total++; if (count_s[33] !== 16'd4) begin bad++; $display("FAIL quad_fwd_count got=%0d want=4", count_s[33]); end

    // -256 needs a direction change first (hold/setup of 1 cycle each), then
    // bit 11 toggles at positions -256, -2304, -4352, -6400.
    do_reset();
    bus.qmode    = 1'b1;
    bus.velocity = 11'h700;
    bus.tap      = 2'd1;
    bus.enable   = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      record(k);
    end
    total++; if ({step_s[3], dir_s[3]} !== 2'b00) begin bad++; $display("FAIL quad_rev0 got=%b want=00", {step_s[3], dir_s[3]}); end
    total++; if ({step_s[4], dir_s[4]} !== 2'b10) begin bad++; $display("FAIL quad_rev1 got=%b want=10", {step_s[4], dir_s[4]}); end
    total++; if ({step_s[12], dir_s[12]} !== 2'b11) begin bad++; $display("FAIL quad_rev2 got=%b want=11", {step_s[12], dir_s[12]}); end
    total++; if ({step_s[20], dir_s[20]} !== 2'b01) begin bad++; $display("FAIL quad_rev3 got=%b want=01", {step_s[20], dir_s[20]}); end
    total++; if ({step_s[28], dir_s[28]} !== 2'b00) begin bad++; $display("FAIL quad_rev4 got=%b want=00", {step_s[28], dir_s[28]}); end
    total++; if (count_s[28] !== 16'hFFFC) begin bad++; $display("FAIL quad_rev_count got=%0h want=fffc", count_s[28]); end
  endtask

  task automatic test_enable_reset();
    do_reset();
    bus.velocity = 11'h200;
    bus.tap      = 2'd1;
    bus.steplen  = 5'd7;
    bus.enable   = 1'b1;
    repeat (7) tick();
    bus.enable = 1'b0;
    repeat (5) tick();
    total++; if (bus.position !== 22'd3584) begin bad++; $display("FAIL en_position got=%0d want=3584", bus.position); end
    total++; if (bus.count !== 16'd1) begin bad++; $display("FAIL en_count got=%0d want=1", bus.count); end
    total++; if (bus.step !== 1'b1) begin bad++; $display("FAIL en_step got=%b want=1", bus.step); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL en_busy got=%b want=1", bus.busy); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (bus.step !== 1'b0) begin bad++; $display("FAIL rst_step got=%b want=0", bus.step); end
    total++; if (bus.position !== 22'd0) begin bad++; $display("FAIL rst_position got=%0d want=0", bus.position); end
    total++; if (bus.count !== 16'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", bus.count); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_rate();
    test_overrun();
    test_dir_change();
    test_pulse_widths();
    test_quadrature();
    test_enable_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
